// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster totals and colour-bar table
package video_timing_pkg;

    localparam int BAR_COUNT = 8;

    // {r, g, b} channel enables per bar, leftmost bar at index 0
    localparam logic [BAR_COUNT-1:0][2:0] BAR_MASK = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic int h_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    function automatic int v_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - pixel request and video output bundle
interface video_timing_gen_if #(
    parameter int CNT_W = 11,
    parameter int PIX_W = 16
);
    logic             data_req;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             frame_start;
    logic             line_start;
    logic [PIX_W-1:0] pixel_data;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_en;
    logic [PIX_W-1:0] vga_rgb;

    modport master (
        output data_req, pixel_xpos, pixel_ypos, frame_start, line_start,
        output vga_hs, vga_vs, vga_en, vga_rgb,
        input  pixel_data
    );

    modport slave (
        input  data_req, pixel_xpos, pixel_ypos, frame_start, line_start,
        input  vga_hs, vga_vs, vga_en, vga_rgb,
        output pixel_data
    );
endinterface

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - fixed-depth register delay line with async clear
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];
endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with pixel-fetch lead and colour bars
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_DISP   = 1024,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int V_DISP   = 768,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int R_W      = 5,
    parameter int G_W      = 6,
    parameter int B_W      = 5,
    parameter int CNT_W    = 11,
    parameter int REQ_LEAD = 1
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic               pattern_en,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL  = h_total(H_DISP, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = v_total(V_DISP, V_FRONT, V_SYNC, V_BACK);
    localparam int HS_BEGIN = H_DISP + H_FRONT;
    localparam int HS_END   = HS_BEGIN + H_SYNC;
    localparam int VS_BEGIN = V_DISP + V_FRONT;
    localparam int VS_END   = VS_BEGIN + V_SYNC;
    localparam int BAR_W    = H_DISP / BAR_COUNT;
    localparam int PIX_W    = R_W + G_W + B_W;
    localparam int DLY_W    = CNT_W + 3;

    generate
        if (REQ_LEAD < 1 || REQ_LEAD > 4) begin : g_bad_lead
            $fatal(1, "video_timing_gen: REQ_LEAD must be in 1..4");
        end
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt
            $fatal(1, "video_timing_gen: CNT_W too small for the raster totals");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_h, cnt_v;
    int               h_pos, v_pos;
    logic             h_last, v_last, h_act, v_act, hs_flag, vs_flag;

    assign h_pos   = 32'(cnt_h);
    assign v_pos   = 32'(cnt_v);
    assign h_last  = (h_pos == H_TOTAL - 1);
    assign v_last  = (v_pos == V_TOTAL - 1);
    assign h_act   = (h_pos < H_DISP);
    assign v_act   = (v_pos < V_DISP);
    assign hs_flag = (h_pos >= HS_BEGIN) && (h_pos < HS_END);
    assign vs_flag = (v_pos >= VS_BEGIN) && (v_pos < VS_END);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (h_last) begin
            cnt_h <= '0;
            cnt_v <= v_last ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    // Request stage: one register after the counters, sync flags travel alongside
    logic req_hs, req_vs;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vif.data_req    <= 1'b0;
            vif.pixel_xpos  <= '0;
            vif.pixel_ypos  <= '0;
            vif.frame_start <= 1'b0;
            vif.line_start  <= 1'b0;
            req_hs          <= 1'b0;
            req_vs          <= 1'b0;
        end else begin
            vif.data_req    <= h_act && v_act;
            vif.pixel_xpos  <= (h_act && v_act) ? cnt_h : '0;
            vif.pixel_ypos  <= (h_act && v_act) ? cnt_v : '0;
            vif.frame_start <= (cnt_h == '0) && (cnt_v == '0);
            vif.line_start  <= (cnt_h == '0) && v_act;
            req_hs          <= hs_flag;
            req_vs          <= vs_flag;
        end
    end

    logic [DLY_W-1:0] dly_in, dly_out;
    logic             d_hs, d_vs, d_en;
    logic [CNT_W-1:0] d_x;

    assign dly_in = {req_hs, req_vs, vif.data_req, vif.pixel_xpos};
    assign {d_hs, d_vs, d_en, d_x} = dly_out;

    sig_delay #(
        .WIDTH (DLY_W),
        .DEPTH (REQ_LEAD)
    ) u_delay (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .d     (dly_in),
        .q     (dly_out)
    );

    // Bar tracking follows the delayed x so colours line up with vga_en
    logic             pat_active;
    logic [2:0]       bar_idx, cur_idx;
    logic [CNT_W-1:0] bar_cnt, cur_cnt;
    logic [2:0]       mask;
    logic [PIX_W-1:0] bar_rgb;

    always_comb begin
        cur_idx = bar_idx;
        cur_cnt = bar_cnt;
        if (d_x == '0) begin
            cur_idx = '0;
            cur_cnt = '0;
        end
    end

    assign mask    = BAR_MASK[cur_idx];
    assign bar_rgb = {{R_W{mask[2]}}, {G_W{mask[1]}}, {B_W{mask[0]}}};

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_active <= 1'b0;
            bar_idx    <= '0;
            bar_cnt    <= '0;
        end else begin
            if (h_last && v_last) pat_active <= pattern_en;
            if (d_en) begin
                if (cur_cnt == CNT_W'(BAR_W - 1) && cur_idx != 3'(BAR_COUNT - 1)) begin
                    bar_idx <= cur_idx + 3'd1;
                    bar_cnt <= '0;
                end else begin
                    bar_idx <= cur_idx;
                    bar_cnt <= cur_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vif.vga_hs  <= !HS_POL;
            vif.vga_vs  <= !VS_POL;
            vif.vga_en  <= 1'b0;
            vif.vga_rgb <= '0;
        end else begin
            vif.vga_hs  <= d_hs ? HS_POL : !HS_POL;
            vif.vga_vs  <= d_vs ? VS_POL : !VS_POL;
            vif.vga_en  <= d_en;
            vif.vga_rgb <= d_en ? (pat_active ? bar_rgb : vif.pixel_data) : '0;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
    localparam int HD = 36, HF = 4, HS = 6, HB = 6, HT = 52;
    localparam int VD = 8, VF = 2, VS = 2, VB = 3, VT = 15;
    localparam int FT = HT * VT;

    typedef struct {
        int          t;
        logic [15:0] rgb;
    } exp_t;

    logic clk, rst_n, pattern_en;
    int   t;
    int   checks, errors;
    exp_t q0[$], q1[$];

    int en_rise[2], hs_prev[2], vs_start[2], fr_en_rise[2], fs_prev[2], ls_cnt[2];
    bit need_first[2], mode[2], hs_d[2], vs_d[2], en_d[2];

    video_timing_gen_if #(.CNT_W(8), .PIX_W(16)) if_a ();
    video_timing_gen_if #(.CNT_W(8), .PIX_W(16)) if_b ();

    video_timing_gen #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .R_W(5), .G_W(6), .B_W(5),
        .CNT_W(8), .REQ_LEAD(1)
    ) dut_a (
        .vga_clk(clk), .sys_rst_n(rst_n), .pattern_en(pattern_en), .vif(if_a)
    );

    video_timing_gen #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .R_W(5), .G_W(6), .B_W(5),
        .CNT_W(8), .REQ_LEAD(3)
    ) dut_b (
        .vga_clk(clk), .sys_rst_n(rst_n), .pattern_en(pattern_en), .vif(if_b)
    );

    // Pixel sources returning the requested x after their own latency
    logic [15:0] src_a;
    logic [15:0] src_b [3];
    always @(posedge clk) begin
        src_a    <= 16'(if_a.pixel_xpos);
        src_b[0] <= 16'(if_b.pixel_xpos);
        src_b[1] <= src_b[0];
        src_b[2] <= src_b[1];
    end
    assign if_a.pixel_data = src_a;
    assign if_b.pixel_data = src_b[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at t=%0d", tag, got, exp, t);
        end
    endtask

    function automatic logic [15:0] bar_exp(input int x);
        int b;
        b = x / (HD / 8);
        if (b > 7) b = 7;
        case (b)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic rst_checks(input string who, input bit req, input logic [7:0] x, input logic [7:0] y,
                              input bit fs, input bit ls, input bit hs, input bit vs, input bit en,
                              input logic [15:0] rgb, input bit hs_idle, input bit vs_idle);
        check_eq({who, "_rst_data_req"}, req, 0);
        check_eq({who, "_rst_xy"}, {x, y}, 0);
        check_eq({who, "_rst_strobes"}, {fs, ls}, 0);
        check_eq({who, "_rst_hs"}, hs, hs_idle);
        check_eq({who, "_rst_vs"}, vs, vs_idle);
        check_eq({who, "_rst_en"}, en, 0);
        check_eq({who, "_rst_rgb"}, rgb, 0);
    endtask

    task automatic mon(input int id, input int lead, input bit hs_a, input bit vs_a, input bit req,
                       input logic [7:0] x, input logic [7:0] y, input bit fs, input bit ls,
                       input bit en, input logic [15:0] rgb);
        int   c, h, v, depth;
        bit   exp_req;
        exp_t e;
        if (!rst_n || t == 0) begin
            if (id == 0) q0.delete(); else q1.delete();
            en_rise[id] = -1; hs_prev[id] = -1; vs_start[id] = -1;
            fr_en_rise[id] = -1; fs_prev[id] = -1; ls_cnt[id] = 0;
            need_first[id] = 0; mode[id] = 0; hs_d[id] = 0; vs_d[id] = 0; en_d[id] = 0;
        end else begin
            c = t - 1;
            h = c % HT;
            v = (c / HT) % VT;
            exp_req = (h < HD) && (v < VD);
            check_eq("data_req", req, exp_req);
            check_eq("pixel_xpos", x, exp_req ? h : 0);
            check_eq("pixel_ypos", y, exp_req ? v : 0);
            check_eq("frame_start", fs, (c % FT) == 0);
            check_eq("line_start", ls, (h == 0) && (v < VD));

            if ((c % FT) == 0) begin
                mode[id] = (c == 0) ? 1'b0 : pattern_en;
                need_first[id] = 1;
            end
            if (fs) begin
                if (fs_prev[id] >= 0) begin
                    check_eq("frame_period", t - fs_prev[id], FT);
                    check_eq("lines_per_frame", ls_cnt[id], VD);
                end
                fs_prev[id] = t;
                ls_cnt[id] = 0;
            end
            if (ls) ls_cnt[id]++;

            if (exp_req) begin
                e.t = t;
                e.rgb = mode[id] ? bar_exp(h) : 16'(h);
                if (id == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (en) begin
                depth = (id == 0) ? q0.size() : q1.size();
                check_eq("sb_has_entry", depth > 0, 1);
                if (depth > 0) begin
                    e = (id == 0) ? q0.pop_front() : q1.pop_front();
                    check_eq("en_latency", t - e.t, lead + 1);
                    check_eq("rgb", rgb, e.rgb);
                end
            end else begin
                check_eq("rgb_blank", rgb, 0);
            end

            if (en && !en_d[id]) begin
                en_rise[id] = t;
                if (need_first[id]) begin
                    fr_en_rise[id] = t;
                    need_first[id] = 0;
                end
            end
            if (!en && en_d[id]) check_eq("en_width", t - en_rise[id], HD);

            if (hs_a && !hs_d[id]) begin
                if (hs_prev[id] >= 0) check_eq("hs_period", t - hs_prev[id], HT);
                if (en_rise[id] >= 0 && (t - en_rise[id]) < HT)
                    check_eq("hs_offset", t - en_rise[id], HD + HF);
                hs_prev[id] = t;
            end
            if (!hs_a && hs_d[id]) check_eq("hs_width", t - hs_prev[id], HS);

            if (vs_a && !vs_d[id]) begin
                vs_start[id] = t;
                if (fr_en_rise[id] >= 0) check_eq("vs_offset", t - fr_en_rise[id], (VD + VF) * HT);
            end
            if (!vs_a && vs_d[id]) check_eq("vs_width", t - vs_start[id], VS * HT);

            en_d[id] = en;
            hs_d[id] = hs_a;
            vs_d[id] = vs_a;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, if_a.vga_hs == 1'b1, if_a.vga_vs == 1'b1, if_a.data_req, if_a.pixel_xpos,
            if_a.pixel_ypos, if_a.frame_start, if_a.line_start, if_a.vga_en, if_a.vga_rgb);
        mon(1, 3, if_b.vga_hs == 1'b0, if_b.vga_vs == 1'b0, if_b.data_req, if_b.pixel_xpos,
            if_b.pixel_ypos, if_b.frame_start, if_b.line_start, if_b.vga_en, if_b.vga_rgb);
    end

    task automatic wait_t(input int n);
        int k;
        k = 0;
        while (t < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_t_reached", t >= n, 1);
    endtask

    task automatic both_rst_checks();
        rst_checks("a", if_a.data_req, if_a.pixel_xpos, if_a.pixel_ypos, if_a.frame_start,
                   if_a.line_start, if_a.vga_hs, if_a.vga_vs, if_a.vga_en, if_a.vga_rgb, 1'b0, 1'b0);
        rst_checks("b", if_b.data_req, if_b.pixel_xpos, if_b.pixel_ypos, if_b.frame_start,
                   if_b.line_start, if_b.vga_hs, if_b.vga_vs, if_b.vga_en, if_b.vga_rgb, 1'b1, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        pattern_en = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 both_rst_checks();
        @(negedge clk);
        rst_n = 1'b1;

        wait_t(FT + 4 * HT + 5);
        pattern_en = 1'b1;
        wait_t(2 * FT + 4 * HT + 5);
        pattern_en = 1'b0;
        wait_t(4 * FT + 5 * HT + 8);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 both_rst_checks();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_t(FT + 11 * HT + 20);
        check_eq("sb_drain_a", q0.size(), 0);
        check_eq("sb_drain_b", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
